// File: rtl/timer_halt_ctrl_pkg.sv
// ============================================================================
// timer_halt_ctrl_pkg : debug-halt FSM state encodings and shared defaults
// Revision 1.0
// ============================================================================
`default_nettype none

package timer_halt_ctrl_pkg;

   // Encodings are shared with the debug register bank for status decode
   localparam logic [2:0] C_ST_IDLE   = 3'd0;
   localparam logic [2:0] C_ST_REQ    = 3'd1;
   localparam logic [2:0] C_ST_HALTED = 3'd2;
   localparam logic [2:0] C_ST_STEP   = 3'd3;
   localparam logic [2:0] C_ST_REL    = 3'd4;

   localparam int C_ACK_TIMEOUT_DEF = 16;
   localparam int C_TO_W_DEF        = 8;

   function automatic logic st_is_busy(input logic [2:0] st);
      return (st == C_ST_REQ) || (st == C_ST_STEP) || (st == C_ST_REL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/thc_timeout_cnt.sv
// ============================================================================
// thc_timeout_cnt : ack-wait counter with clear/enable and terminal-count flag
// Revision 1.0
// ============================================================================
`default_nettype none

module thc_timeout_cnt #(
   parameter int TO_W        = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TO_W-1:0] C_TC_VAL = TO_W'(ACK_TIMEOUT - 1);

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tc = (r_cnt == C_TC_VAL);

endmodule

`default_nettype wire

// File: rtl/timer_halt_ctrl.sv
// ============================================================================
// timer_halt_ctrl : initiator side of the timer debug-halt handshake
// Revision 1.0
// ============================================================================
`default_nettype none

module timer_halt_ctrl
   import timer_halt_ctrl_pkg::*;
#(
   parameter int ACK_TIMEOUT = C_ACK_TIMEOUT_DEF,
   parameter int TO_W        = C_TO_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic dbg_mode,
   input  logic halt_cmd,
   input  logic resume_cmd,
   input  logic step_cmd,
   input  logic err_clr,
   input  logic halt_ack,
   input  logic cnt_en,
   output logic halt_req,
   output logic halted,
   output logic busy,
   output logic step_done,
   output logic timeout_err
);

   logic [2:0] r_state;
   logic [2:0] w_next;
   logic       r_stepping;
   logic       w_stepping_next;
   logic       w_set_err;
   logic       w_tc;

   // Counter sits at zero outside REQ, so every REQ entry starts a fresh wait
   thc_timeout_cnt #(
      .TO_W        (TO_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_to_cnt (
      .clk (clk),
      .rst (rst),
      .clr (r_state != C_ST_REQ),
      .en  (r_state == C_ST_REQ),
      .tc  (w_tc)
   );

   always_comb begin
      w_next    = r_state;
      w_set_err = 1'b0;
      case (r_state)
         C_ST_IDLE: begin
            if (halt_cmd && dbg_mode) w_next = C_ST_REQ;
         end
         C_ST_REQ: begin
            if (!dbg_mode)       w_next = C_ST_IDLE;
            else if (halt_ack)   w_next = C_ST_HALTED;
            else if (resume_cmd) w_next = C_ST_REL;
            else if (w_tc) begin
               w_next    = C_ST_IDLE;
               w_set_err = 1'b1;
            end
         end
         C_ST_HALTED: begin
            if (resume_cmd)      w_next = C_ST_REL;
            else if (step_cmd)   w_next = C_ST_STEP;
            else if (!halt_ack)  w_next = C_ST_IDLE;
         end
         C_ST_STEP: begin
            if (!dbg_mode)       w_next = C_ST_IDLE;
            else if (resume_cmd) w_next = C_ST_REL;
            else if (cnt_en)     w_next = C_ST_REQ;
         end
         C_ST_REL: begin
            if (!halt_ack)       w_next = C_ST_IDLE;
         end
         default: w_next = C_ST_IDLE;
      endcase
   end

   // Marks a REQ phase that was entered by finishing a single step
   assign w_stepping_next = (w_next == C_ST_REQ) &&
                            ((r_state == C_ST_STEP) || ((r_state == C_ST_REQ) && r_stepping));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= C_ST_IDLE;
         r_stepping  <= 1'b0;
         halt_req    <= 1'b0;
         halted      <= 1'b0;
         busy        <= 1'b0;
         step_done   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_stepping <= w_stepping_next;
         halt_req   <= (w_next == C_ST_REQ) || (w_next == C_ST_HALTED);
         halted     <= (w_next == C_ST_HALTED);
         busy       <= st_is_busy(w_next);
         step_done  <= (w_next == C_ST_HALTED) && (r_state == C_ST_REQ) && r_stepping;
         if (w_set_err) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire
